// File: rtl/bin_to_bcd_seq_if.sv
// Valid/ready handshake bundle for the sequential binary-to-BCD converter.
// The producer and consumer of conversions use "master"; the converter uses "slave".
interface bin_to_bcd_seq_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      bin_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  sign_out;

  modport master (
    output in_valid, bin_in, out_ready,
    input  in_ready, out_valid, bcd_out, sign_out
  );

  modport slave (
    input  in_valid, bin_in, out_ready,
    output in_ready, out_valid, bcd_out, sign_out
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one operand bit per clock,
// with optional two's-complement input converted as sign plus magnitude.
module bin_to_bcd_seq #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIGITS    = 3,
  parameter bit          SIGNED_IN = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  bin_to_bcd_seq_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned AccW = 4 * DIGITS;

  function automatic bit params_ok();
    longint unsigned p10;
    if (WIDTH < 1 || WIDTH > 32) return 1'b0;
    if (SIGNED_IN && WIDTH < 2) return 1'b0;
    if (DIGITS < 1) return 1'b0;
    if (DIGITS >= 10) return 1'b1;
    p10 = 1;
    for (int unsigned i = 0; i < DIGITS; i++) p10 = p10 * 10;
    return p10 > ((64'd1 << WIDTH) - 64'd1);
  endfunction

  if (!params_ok()) begin : g_bad_params
    $fatal(1, "bin_to_bcd_seq: illegal WIDTH/DIGITS/SIGNED_IN combination");
  end

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  opnd_q, opnd_d;
  logic [AccW-1:0]   acc_q, acc_d, acc_adj, acc_shl;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic [AccW-1:0]   bcd_q, bcd_d;
  logic              sign_q, sign_d;

  // All digits are tested on their pre-adjust values, so the path is one
  // compare/add per digit regardless of WIDTH.
  always_comb begin
    acc_adj = acc_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    acc_shl = AccW'({acc_adj, opnd_q[WIDTH-1]});
  end

  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    bcd_d   = bcd_q;
    sign_d  = sign_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          if (SIGNED_IN && bus.bin_in[WIDTH-1]) begin
            opnd_d = ~bus.bin_in + WIDTH'(1);
            neg_d  = 1'b1;
          end else begin
            opnd_d = bus.bin_in;
            neg_d  = 1'b0;
          end
          acc_d   = '0;
          cnt_d   = CntW'(WIDTH);
          state_d = StShift;
        end
      end
      StShift: begin
        acc_d  = acc_shl;
        opnd_d = opnd_q << 1;
        cnt_d  = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          bcd_d   = acc_shl;
          sign_d  = neg_q;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      opnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      bcd_q   <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      bcd_q   <= bcd_d;
      sign_q  <= sign_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle) && !rst;
  assign bus.out_valid = (state_q == StDone);
  assign bus.bcd_out   = bcd_q;
  assign bus.sign_out  = sign_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: three configurations (8b unsigned, 8b signed, 16b/5 digits)
// driven by a vector table, hand sequences and random operands against a decimal model.
module tb_bin_to_bcd_seq;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) if_u ();
  bin_to_bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) if_s ();
  bin_to_bcd_seq_if #(.WIDTH(16), .DIGITS(5)) if_w ();

  bin_to_bcd_seq #(.WIDTH(8),  .DIGITS(3), .SIGNED_IN(1'b0)) dut_u (.clk(clk), .rst(rst), .bus(if_u));
  bin_to_bcd_seq #(.WIDTH(8),  .DIGITS(3), .SIGNED_IN(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(if_s));
  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED_IN(1'b0)) dut_w (.clk(clk), .rst(rst), .bus(if_w));

  typedef struct {
    int           sel;
    logic [15:0]  val;
    logic [19:0]  bcd;
    logic         sign;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input int sel, input logic v, input logic [15:0] d);
    case (sel)
      0:       begin if_u.in_valid = v; if_u.bin_in = d[7:0]; end
      1:       begin if_s.in_valid = v; if_s.bin_in = d[7:0]; end
      default: begin if_w.in_valid = v; if_w.bin_in = d;      end
    endcase
  endtask

  task automatic set_ordy(input int sel, input logic v);
    case (sel)
      0:       if_u.out_ready = v;
      1:       if_s.out_ready = v;
      default: if_w.out_ready = v;
    endcase
  endtask

  function automatic logic get_ready(input int sel);
    case (sel)
      0:       return if_u.in_ready;
      1:       return if_s.in_ready;
      default: return if_w.in_ready;
    endcase
  endfunction

  function automatic logic get_ovalid(input int sel);
    case (sel)
      0:       return if_u.out_valid;
      1:       return if_s.out_valid;
      default: return if_w.out_valid;
    endcase
  endfunction

  function automatic logic [19:0] get_bcd(input int sel);
    case (sel)
      0:       return {8'd0, if_u.bcd_out};
      1:       return {8'd0, if_s.bcd_out};
      default: return if_w.bcd_out;
    endcase
  endfunction

  function automatic logic get_sign(input int sel);
    case (sel)
      0:       return if_u.sign_out;
      1:       return if_s.sign_out;
      default: return if_w.sign_out;
    endcase
  endfunction

  // Reference: signed/unsigned integer value, then repeated divide by ten.
  function automatic logic [20:0] model(input int sel, input logic [15:0] d);
    int          v;
    int          ndig;
    logic        neg;
    logic [19:0] b;
    if (sel == 1)      v = int'($signed(d[7:0]));
    else if (sel == 0) v = int'(d[7:0]);
    else               v = int'(d);
    neg  = (v < 0);
    if (neg) v = -v;
    ndig = (sel == 2) ? 5 : 3;
    b    = '0;
    for (int i = 0; i < ndig; i++) begin
      b[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return {neg, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; gap sets idle cycles before the request and back-pressure cycles.
  task automatic xact(input int sel, input logic [15:0] d, input int gap,
                      output logic [19:0] bcd, output logic sgn, output int lat);
    int n;
    repeat (gap) tick();
    set_in(sel, 1'b1, d);
    n = 0;
    while (!get_ready(sel) && n < 100) begin tick(); n++; end
    tick();
    set_in(sel, 1'b0, ~d);
    lat = 0;
    while (!get_ovalid(sel) && lat < 100) begin tick(); lat++; end
    bcd = get_bcd(sel);
    sgn = get_sign(sel);
    repeat (gap) tick();
    set_ordy(sel, 1'b1);
    tick();
    set_ordy(sel, 1'b0);
  endtask

  task automatic run(input int sel, input logic [15:0] d, input int gap,
                     input logic [19:0] ebcd, input logic esign, input string tag);
    logic [19:0] b;
    logic        s;
    int          lat;
    xact(sel, d, gap, b, s, lat);
    check({tag, "_bcd"},  32'(b), 32'(ebcd));
    check({tag, "_sign"}, 32'(s), 32'(esign));
    check({tag, "_lat"},  32'(lat), (sel == 2) ? 32'd16 : 32'd8);
  endtask

  initial begin
    vec_t        vecs[10];
    logic [20:0] m;
    logic [15:0] d;
    int          sel;
    int          n;

    vecs[0] = '{0, 16'd255,   20'h00255, 1'b0};
    vecs[1] = '{0, 16'd0,     20'h00000, 1'b0};
    vecs[2] = '{0, 16'd100,   20'h00100, 1'b0};
    vecs[3] = '{1, 16'h0080,  20'h00128, 1'b1};
    vecs[4] = '{1, 16'h00FF,  20'h00001, 1'b1};
    vecs[5] = '{1, 16'h007F,  20'h00127, 1'b0};
    vecs[6] = '{1, 16'h0000,  20'h00000, 1'b0};
    vecs[7] = '{2, 16'd65535, 20'h65535, 1'b0};
    vecs[8] = '{2, 16'd10000, 20'h10000, 1'b0};
    vecs[9] = '{2, 16'd9,     20'h00009, 1'b0};

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(i, 1'b0, 16'd0);
      set_ordy(i, 1'b0);
    end
    tick();
    tick();
    check("rst_in_ready", 32'(get_ready(0)), 32'd0);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("post_rst_in_ready", 32'(get_ready(i)), 32'd1);
      check("post_rst_out_valid", 32'(get_ovalid(i)), 32'd0);
      check("post_rst_bcd", 32'(get_bcd(i)), 32'd0);
      check("post_rst_sign", 32'(get_sign(i)), 32'd0);
    end

    foreach (vecs[i]) run(vecs[i].sel, vecs[i].val, i % 3, vecs[i].bcd, vecs[i].sign, "vec");

    // Back-pressure: result held, in_valid dropped while DONE.
    set_in(0, 1'b1, 16'd77);
    tick();
    set_in(0, 1'b0, 16'd0);
    n = 0;
    while (!get_ovalid(0) && n < 100) begin tick(); n++; end
    check("bp_lat", 32'(n), 32'd8);
    check("bp_bcd", 32'(get_bcd(0)), 32'h077);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) set_in(0, 1'b1, 16'd99);
      tick();
      set_in(0, 1'b0, 16'd0);
      check("bp_valid", 32'(get_ovalid(0)), 32'd1);
      check("bp_hold", 32'(get_bcd(0)), 32'h077);
      check("bp_ready", 32'(get_ready(0)), 32'd0);
    end
    set_ordy(0, 1'b1);
    tick();
    set_ordy(0, 1'b0);
    check("bp_release_valid", 32'(get_ovalid(0)), 32'd0);
    check("bp_release_ready", 32'(get_ready(0)), 32'd1);
    check("bp_idle_hold", 32'(get_bcd(0)), 32'h077);
    n = 0;
    repeat (12) begin tick(); if (get_ovalid(0)) n++; end
    check("bp_dropped_pulse", 32'(n), 32'd0);

    // Reset during the 4th shift cycle.
    set_in(0, 1'b1, 16'd200);
    tick();
    set_in(0, 1'b0, 16'd0);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(get_ready(0)), 32'd0);
    tick();
    rst = 1'b0;
    check("midrst_valid", 32'(get_ovalid(0)), 32'd0);
    check("midrst_bcd", 32'(get_bcd(0)), 32'd0);
    check("midrst_sign", 32'(get_sign(1)), 32'd0);
    n = 0;
    repeat (12) begin tick(); if (get_ovalid(0)) n++; end
    check("midrst_no_spurious", 32'(n), 32'd0);
    run(0, 16'd42, 0, 20'h00042, 1'b0, "after_rst");

    for (int i = 0; i < 1000; i++) begin
      sel = int'($urandom_range(0, 2));
      d   = 16'($urandom);
      m   = model(sel, d);
      run(sel, d, int'($urandom_range(0, 3)), m[19:0], m[20], "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
